// File: rtl/dbl_pkg.sv
// Shared binary64 constants, converter state encoding and the field packer.
package dbl_pkg;

  localparam int DBL_BIAS   = 1023;
  localparam int DBL_EXP_W  = 11;
  localparam int DBL_FRAC_W = 52;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [63:0] pack_double(
    input logic                  sign,
    input logic [DBL_EXP_W-1:0]  exp,
    input logic [DBL_FRAC_W-1:0] frac
  );
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/dbl_lzc.sv
// Leading-zero counter: returns W for an all-zero input.
module dbl_lzc #(
  parameter int W = 16
) (
  input  logic [W-1:0]       value,
  output logic [$clog2(W):0] count
);

  localparam int CW = $clog2(W) + 1;

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/int_to_double_conv.sv
// Fixed-point sample to IEEE-754 binary64 converter with valid/ready on both sides.
// INT2DBL_FAST_NORM_EN: normalise in a single cycle with a combinational leading-zero count.
module int_to_double_conv
  import dbl_pkg::*;
#(
  parameter int W         = 16,
  parameter int FRAC_BITS = 0,
  parameter int TWOS_COMP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_sample,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [63:0]  out_double,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and data are held by the source until that edge.

  localparam int LZ_W = $clog2(W) + 1;
  localparam logic [11:0] EXP_BASE = 12'(DBL_BIAS + W - 1 - FRAC_BITS);

  state_t       state_q, state_d;
  logic         sign_q;
  logic [W-1:0] mag_q;
  logic [63:0]  out_q;

  logic [W-1:0]            in_mag;
  logic [W-1:0]            norm_mag;
  logic [LZ_W-1:0]         norm_lz;
  logic                    accept;
  logic                    pack_en;
  logic [DBL_FRAC_W-1:0]   frac;
  logic [DBL_EXP_W-1:0]    exp_field;
  logic [63:0]             result;

  always_comb begin
    in_mag = '0;
    if (TWOS_COMP != 0) begin
      in_mag = in_sample[W-1] ? (~in_sample) + W'(1) : in_sample;
    end else begin
      in_mag = {1'b0, in_sample[W-2:0]};
    end
  end

`ifdef INT2DBL_FAST_NORM_EN
  logic [LZ_W-1:0] lzc_count;

  dbl_lzc #(.W(W)) u_lzc (
    .value(mag_q),
    .count(lzc_count)
  );

  assign norm_mag = mag_q << lzc_count;
  assign norm_lz  = lzc_count;
`else
  logic [LZ_W-1:0] lz_q;

  assign norm_mag = mag_q;
  assign norm_lz  = lz_q;
`endif

  // The implicit leading one is dropped; the rest sits at the top of the fraction.
  assign frac      = DBL_FRAC_W'(norm_mag[W-2:0]) << (DBL_FRAC_W - (W - 1));
  assign exp_field = DBL_EXP_W'(EXP_BASE - 12'(norm_lz));
  assign result    = (mag_q == '0) ? 64'd0 : pack_double(sign_q, exp_field, frac);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    pack_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0 || norm_mag[W-1]) begin
          pack_en = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      out_q  <= '0;
`ifndef INT2DBL_FAST_NORM_EN
      lz_q   <= '0;
`endif
    end else begin
      if (accept) begin
        sign_q <= in_sample[W-1];
        mag_q  <= in_mag;
`ifndef INT2DBL_FAST_NORM_EN
        lz_q   <= '0;
`endif
      end
`ifndef INT2DBL_FAST_NORM_EN
      else if (state_q == NORM && !pack_en) begin
        mag_q <= mag_q << 1;
        lz_q  <= lz_q + LZ_W'(1);
      end
`endif
      if (pack_en) out_q <= result;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_double = out_q;

endmodule

// File: tb/tb_int_to_double_conv.sv
// Directed bench: three converter configurations checked against hand-computed results.
module tb_int_to_double_conv;

`ifdef INT2DBL_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // Instance 0: two's complement, integer. 1: sign-magnitude. 2: FRAC_BITS=15.
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] smp  [3];
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        bz   [3];
  logic [63:0] od   [3];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          k;
    logic [15:0] x;
    logic [63:0] y;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  int_to_double_conv #(.W(16), .FRAC_BITS(0), .TWOS_COMP(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_sample(smp[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_double(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0])
  );

  int_to_double_conv #(.W(16), .FRAC_BITS(0), .TWOS_COMP(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_sample(smp[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_double(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1])
  );

  int_to_double_conv #(.W(16), .FRAC_BITS(15), .TWOS_COMP(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_sample(smp[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .out_double(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bz[2])
  );

  // Latency counts the accepting cycle as cycle 1; gives up after 64 cycles.
  task automatic convert(input int k, input logic [15:0] x,
                         output logic [63:0] res, output int lat);
    @(negedge clk);
    smp[k]  = x;
    iv[k]   = 1'b1;
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 1;
    while (ov[k] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res = od[k];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp[k] = 16'h0; iv[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec += 4;
      if (ov[k] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, ov[k]); end
      if (od[k] !== 64'h0) begin n_err++; $display("FAIL reset_out_double[%0d] got %h want 0", k, od[k]); end
      if (bz[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d] got %b want 0", k, bz[k]); end
      if (ir[k] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d] got %b want 1", k, ir[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_conversions();
    vec_t        tbl [11];
    logic [63:0] res;
    int          lat;
    int          want_lat;
    tbl[0]  = '{0, 16'h0001, 64'h3FF0000000000000, 17};
    tbl[1]  = '{0, 16'hFFFF, 64'hBFF0000000000000, 17};
    tbl[2]  = '{0, 16'h8000, 64'hC0E0000000000000, 2};
    tbl[3]  = '{0, 16'h0000, 64'h0000000000000000, 2};
    tbl[4]  = '{0, 16'h0003, 64'h4008000000000000, 16};
    tbl[5]  = '{0, 16'h7FFF, 64'h40DFFFC000000000, 3};
    tbl[6]  = '{1, 16'h8000, 64'h0000000000000000, 2};
    tbl[7]  = '{1, 16'h8005, 64'hC014000000000000, 15};
    tbl[8]  = '{1, 16'h0001, 64'h3FF0000000000000, 17};
    tbl[9]  = '{2, 16'h4000, 64'h3FE0000000000000, 3};
    tbl[10] = '{2, 16'hC000, 64'hBFE0000000000000, 3};
    for (int i = 0; i < 11; i++) begin
      convert(tbl[i].k, tbl[i].x, res, lat);
      want_lat = FAST ? 2 : tbl[i].lat;
      n_vec += 2;
      if (res !== tbl[i].y) begin
        n_err++;
        $display("FAIL conv[%0d] dut%0d in=%h got %h want %h", i, tbl[i].k, tbl[i].x, res, tbl[i].y);
      end
      if (lat != want_lat) begin
        n_err++;
        $display("FAIL conv_latency[%0d] dut%0d in=%h got %0d want %0d", i, tbl[i].k, tbl[i].x, lat, want_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    smp[0] = 16'h0001; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk); #1;
    smp[0] = 16'h0002;
    lat = 1;
    while (ov[0] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_vec += 3;
      if (ov[0] !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d] got %b want 1", c, ov[0]); end
      if (od[0] !== 64'h3FF0000000000000) begin n_err++; $display("FAIL bp_out_double[%0d] got %h want 3ff0000000000000", c, od[0]); end
      if (ir[0] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, ir[0]); end
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    n_vec += 3;
    if (ov[0] !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", ov[0]); end
    if (ir[0] !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", ir[0]); end
    if (od[0] !== 64'h3FF0000000000000) begin n_err++; $display("FAIL bp_held_result got %h want 3ff0000000000000", od[0]); end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n_vec++;
    if (bz[0] !== 1'b1) begin n_err++; $display("FAIL bp_next_accept_busy got %b want 1", bz[0]); end
    lat = 1;
    while (ov[0] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec += 2;
    if (od[0] !== 64'h4000000000000000) begin n_err++; $display("FAIL bp_second_result got %h want 4000000000000000", od[0]); end
    if (lat != (FAST ? 2 : 16)) begin n_err++; $display("FAIL bp_second_latency got %0d want %0d", lat, FAST ? 2 : 16); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_norm();
    logic [63:0] res;
    int          lat;
    @(negedge clk);
    smp[0] = 16'h0001; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n_vec++;
    if (bz[0] !== 1'b1) begin n_err++; $display("FAIL mid_norm_busy got %b want 1", bz[0]); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec += 4;
    if (ov[0] !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid got %b want 0", ov[0]); end
    if (bz[0] !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", bz[0]); end
    if (ir[0] !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready got %b want 1", ir[0]); end
    if (od[0] !== 64'h0) begin n_err++; $display("FAIL mid_rst_out_double got %h want 0", od[0]); end
    rst = 1'b0;
    convert(0, 16'h0001, res, lat);
    n_vec += 2;
    if (res !== 64'h3FF0000000000000) begin n_err++; $display("FAIL after_rst_result got %h want 3ff0000000000000", res); end
    if (lat != (FAST ? 2 : 17)) begin n_err++; $display("FAIL after_rst_latency got %0d want %0d", lat, FAST ? 2 : 17); end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_backpressure();
    test_reset_mid_norm();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
